// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection, flush/hold handling
// and a saturating count of hazard bubbles.
module id_ex_hazard_reg #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_uses_rs2,
    input  logic [2:0]       id_funct3,
    input  logic             id_funct7,
    input  logic [1:0]       id_alu_op,
    input  logic             id_alu_src,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_reg_write,
    input  logic             id_mem_to_reg,
    input  logic             id_branch,
    input  logic             ex_flush,
    input  logic             ex_hold,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [2:0]       ex_funct3,
    output logic             ex_funct7,
    output logic [1:0]       ex_alu_op,
    output logic             ex_alu_src,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_reg_write,
    output logic             ex_mem_to_reg,
    output logic             ex_branch,
    output logic             stall,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic            funct7;
        logic [1:0]      alu_op;
        logic            alu_src;
        logic            mem_read;
        logic            mem_write;
        logic            reg_write;
        logic            mem_to_reg;
        logic            branch;
    } stage_t;

    stage_t           q, nxt, id_s;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             hz;

    // Load in EX whose destination is read by the instruction in ID (x0 excluded)
    always_comb begin
        hz = q.valid & q.mem_read & (q.rd != 5'd0) & id_valid &
             ((q.rd == id_rs1) | (id_uses_rs2 & (q.rd == id_rs2)));
    end

    assign stall = (hz & ~ex_flush & ~ex_hold) | (ex_hold & ~ex_flush);

    // Next-state selection: flush > hold > hazard bubble > normal load
    always_comb begin
        id_s            = '0;
        id_s.valid      = id_valid;
        id_s.pc         = id_pc;
        id_s.rs1_data   = id_rs1_data;
        id_s.rs2_data   = id_rs2_data;
        id_s.imm        = id_imm;
        id_s.rs1        = id_rs1;
        id_s.rs2        = id_rs2;
        id_s.rd         = id_rd;
        id_s.funct3     = id_funct3;
        id_s.funct7     = id_funct7;
        if (id_valid) begin
            id_s.alu_op     = id_alu_op;
            id_s.alu_src    = id_alu_src;
            id_s.mem_read   = id_mem_read;
            id_s.mem_write  = id_mem_write;
            id_s.reg_write  = id_reg_write;
            id_s.mem_to_reg = id_mem_to_reg;
            id_s.branch     = id_branch;
        end

        nxt     = q;
        cnt_nxt = cnt;
        if (ex_flush) begin
            nxt = '0;
        end else if (!ex_hold) begin
            if (hz) begin
                nxt = '0;
                if (cnt != CNT_MAX) cnt_nxt = cnt + CNT_W'(1);
            end else begin
                nxt = id_s;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q   <= '0;
            cnt <= '0;
        end else begin
            q   <= nxt;
            cnt <= cnt_nxt;
        end
    end

    assign ex_valid      = q.valid;
    assign ex_pc         = q.pc;
    assign ex_rs1_data   = q.rs1_data;
    assign ex_rs2_data   = q.rs2_data;
    assign ex_imm        = q.imm;
    assign ex_rs1        = q.rs1;
    assign ex_rs2        = q.rs2;
    assign ex_rd         = q.rd;
    assign ex_funct3     = q.funct3;
    assign ex_funct7     = q.funct7;
    assign ex_alu_op     = q.alu_op;
    assign ex_alu_src    = q.alu_src;
    assign ex_mem_read   = q.mem_read;
    assign ex_mem_write  = q.mem_write;
    assign ex_reg_write  = q.reg_write;
    assign ex_mem_to_reg = q.mem_to_reg;
    assign ex_branch     = q.branch;
    assign bubble_cnt    = cnt;

endmodule
